fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_wr_arbiter_pkg.sv | 29 ++
 rtl/fifo_wr_arbiter_if.sv | 28 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 26 ++
 rtl/fifo_wr_arbiter.sv | 123 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-side scheduler and its rotate-priority picker.
// The optional header word is enabled by the FIFO_ARB_HDR_EN macro in the top module.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    HDR   = 2'd2
  } arb_state_e;

  // Widest requester vector the picker supports.
  localparam int RR_MAX = 8;

  // The header marker sits in the MSB of the data word.
  function automatic int hdr_mark_bit(input int dsize);
    return dsize - 1;
  endfunction

  // First set bit searching upward from ptr+1, modulo nreq; returns ptr when none is set.
  function automatic int rr_next(input logic [RR_MAX-1:0] req, input int ptr, input int nreq);
    int idx;
    rr_next = ptr;
    for (int k = nreq; k >= 1; k--) begin
      idx = (ptr + k) % nreq;
      if (req[idx]) rr_next = idx;
    end
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester / FIFO write-port bundle shared between the write scheduler (slave) and its users (master).
interface fifo_wr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8
);
  localparam int OW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       ack;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic                  wfull;
  logic                  busy;
  logic [OW-1:0]         owner;

  modport slave (
    input  req, req_data, req_last, wfull,
    output ack, winc, wdata, busy, owner
  );

  modport master (
    output req, req_data, req_last, wfull,
    input  ack, winc, wdata, busy, owner
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: picks the first set req above rr_ptr, wrapping at NREQ.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   rr_ptr,
  output logic [PW-1:0]   sel,
  output logic            any
);

  if (NREQ < 2 || NREQ > RR_MAX) begin : g_bad_nreq
    $error("rr_pick: NREQ must be in 2..%0d", RR_MAX);
  end

  logic [RR_MAX-1:0] req_w;

  always_comb begin
    req_w = RR_MAX'(req);
    sel   = PW'(rr_next(req_w, int'(rr_ptr), NREQ));
    any   = |req;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-granular, wfull-aware scheduler for the async FIFO write port.
// Define FIFO_ARB_HDR_EN to prefix every burst with a header word {1, zeros, owner}.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DSIZE     = 8,
  parameter int BURST_MAX = 16
) (
  input  logic              wclk,
  input  logic              wrst_n,
  fifo_wr_arbiter_if.slave  bus
);

  localparam int OW = $clog2(NREQ);
  localparam int CW = $clog2(BURST_MAX);

  if (BURST_MAX < 2 || (BURST_MAX & (BURST_MAX - 1)) != 0) begin : g_bad_burst
    $error("fifo_wr_arbiter: BURST_MAX must be a power of 2 and >= 2");
  end

  arb_state_e     state;
  logic [OW-1:0]  owner;
  logic [OW-1:0]  rr_ptr;
  logic [OW-1:0]  sel;
  logic [CW-1:0]  beat_cnt;
  logic           any;
  logic           own_req;
  logic           own_last;
  logic           accept;
  logic           burst_end;

  rr_pick #(.NREQ(NREQ), .PW(OW)) u_rr_pick (
    .req    (bus.req),
    .rr_ptr (rr_ptr),
    .sel    (sel),
    .any    (any)
  );

  assign own_req   = bus.req[owner];
  assign own_last  = bus.req_last[owner];
  assign accept    = (state == BURST) && own_req && !bus.wfull;
  assign burst_end = own_last || (beat_cnt == CW'(BURST_MAX - 1));

`ifdef FIFO_ARB_HDR_EN
  localparam int HDR_MARK_BIT = hdr_mark_bit(DSIZE);

  if (DSIZE <= OW) begin : g_bad_hdr
    $error("fifo_wr_arbiter: DSIZE must exceed $clog2(NREQ) for the header word");
  end

  logic [DSIZE-1:0] hdr_word;

  always_comb begin
    hdr_word               = '0;
    hdr_word[HDR_MARK_BIT] = 1'b1;
    hdr_word[OW-1:0]       = owner;
  end
`endif

  // wfull only rises after the filling write, so gating winc with the live flag never overruns.
  always_comb begin
    bus.ack   = '0;
    bus.winc  = 1'b0;
    bus.wdata = bus.req_data[int'(owner)*DSIZE +: DSIZE];
    if (accept) begin
      bus.ack[owner] = 1'b1;
      bus.winc       = 1'b1;
    end
`ifdef FIFO_ARB_HDR_EN
    if (state == HDR) begin
      bus.winc  = !bus.wfull;
      bus.wdata = hdr_word;
    end
`endif
  end

  assign bus.busy  = (state != IDLE);
  assign bus.owner = owner;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= OW'(NREQ - 1);
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            owner    <= sel;
            beat_cnt <= '0;
`ifdef FIFO_ARB_HDR_EN
            state    <= HDR;
`else
            state    <= BURST;
`endif
          end
        end
`ifdef FIFO_ARB_HDR_EN
        HDR: begin
          if (!bus.wfull) state <= BURST;
        end
`endif
        BURST: begin
          // A dropped req without last abandons the burst; no write happens that cycle.
          if (!own_req) begin
            state  <= IDLE;
            rr_ptr <= owner;
          end else if (!bus.wfull) begin
            beat_cnt <= beat_cnt + CW'(1);
            if (burst_end) begin
              state  <= IDLE;
              rr_ptr <= owner;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: requester queues feed the DUT, FIFO writes and acks are logged.
module tb_fifo_wr_arbiter;

  localparam int NREQ      = 4;
  localparam int DSIZE     = 8;
  localparam int BURST_MAX = 16;

  logic wclk   = 1'b0;
  logic wrst_n = 1'b0;

  always #5 wclk = ~wclk;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .DSIZE(DSIZE)) bus ();

  fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .BURST_MAX(BURST_MAX)) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DSIZE-1:0] qd [NREQ][$];
  logic             ql [NREQ][$];
  logic [NREQ-1:0]  en;
  logic [DSIZE-1:0] wr_log [$];
  logic [DSIZE-1:0] hdr_log [$];
  int               ack_log [$];
  logic [31:0]      ack0_hist;
  logic             s_winc;
  logic [NREQ-1:0]  s_ack;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (en[i] && qd[i].size() > 0) begin
        bus.req[i]                     = 1'b1;
        bus.req_data[i*DSIZE +: DSIZE] = qd[i][0];
        bus.req_last[i]                = ql[i][0];
      end else begin
        bus.req[i]                     = 1'b0;
        bus.req_data[i*DSIZE +: DSIZE] = '0;
        bus.req_last[i]                = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(negedge wclk);
    s_winc    = bus.winc;
    s_ack     = bus.ack;
    ack0_hist = {ack0_hist[30:0], bus.ack[0]};
    if (bus.winc) begin
      if (bus.ack == '0) hdr_log.push_back(bus.wdata);
      else               wr_log.push_back(bus.wdata);
    end
    for (int i = 0; i < NREQ; i++) begin
      if (bus.ack[i]) begin
        ack_log.push_back(i);
        void'(qd[i].pop_front());
        void'(ql[i].pop_front());
      end
    end
    @(posedge wclk);
    #1;
    drive();
  endtask

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < NREQ; i++) if (en[i]) n += qd[i].size();
    return n;
  endfunction

  task automatic run_until_idle(input string tag, input int budget);
    int n = 0;
    while ((pending() > 0 || bus.busy) && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, 32'(n < budget), 32'd1);
  endtask

  task automatic push(input int r, input logic [DSIZE-1:0] d, input logic last);
    qd[r].push_back(d);
    ql[r].push_back(last);
  endtask

  task automatic clear_logs();
    wr_log.delete();
    hdr_log.delete();
    ack_log.delete();
    ack0_hist = '0;
  endtask

  task automatic reset_dut(input string tag);
    wrst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      qd[i].delete();
      ql[i].delete();
    end
    en       = '1;
    bus.wfull = 1'b0;
    drive();
    #1;
    chk({tag, "_rst_winc"},  32'(bus.winc),  32'd0);
    chk({tag, "_rst_ack"},   32'(bus.ack),   32'd0);
    chk({tag, "_rst_busy"},  32'(bus.busy),  32'd0);
    chk({tag, "_rst_owner"}, 32'(bus.owner), 32'd0);
    @(posedge wclk);
    #1;
    wrst_n = 1'b1;
    clear_logs();
  endtask

  task automatic chk_wr(input string tag, input logic [DSIZE-1:0] exp[$]);
    chk({tag, "_n"}, 32'(wr_log.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), (i < wr_log.size()) ? 32'(wr_log[i]) : 32'hFFFF_FFFF, 32'(exp[i]));
  endtask

  task automatic chk_ack(input string tag, input int exp[$]);
    chk({tag, "_n"}, 32'(ack_log.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), (i < ack_log.size()) ? 32'(ack_log[i]) : 32'hFFFF_FFFF, 32'(exp[i]));
  endtask

  initial begin
    logic [DSIZE-1:0] e8 [$];
    int               ea [$];
    int               n;

    bus.req      = '0;
    bus.req_data = '0;
    bus.req_last = '0;
    bus.wfull    = 1'b0;
    en           = '1;

    // Single requester, three-word burst
    reset_dut("t1");
    push(0, 8'h11, 1'b0);
    push(0, 8'h22, 1'b0);
    push(0, 8'h33, 1'b1);
    drive();
    repeat (6) tick();
`ifdef FIFO_ARB_HDR_EN
    chk("t1_ack0_pattern", 32'(ack0_hist[5:0]), 32'b001110);
`else
    chk("t1_ack0_pattern", 32'(ack0_hist[5:0]), 32'b011100);
`endif
    chk("t1_busy_after", 32'(bus.busy), 32'd0);
    e8 = '{8'h11, 8'h22, 8'h33};
    chk_wr("t1_wr", e8);

    // All four requesting with one-word bursts
    reset_dut("t2");
    push(0, 8'h10, 1'b1);
    push(0, 8'h50, 1'b1);
    push(1, 8'h20, 1'b1);
    push(2, 8'h30, 1'b1);
    push(3, 8'h40, 1'b1);
    drive();
    run_until_idle("t2", 100);
    ea = '{0, 1, 2, 3, 0};
    chk_ack("t2_ack", ea);
    e8 = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    chk_wr("t2_wr", e8);
`ifdef FIFO_ARB_HDR_EN
    chk("t2_hdr_n", 32'(hdr_log.size()), 32'd5);
    if (hdr_log.size() == 5) begin
      chk("t2_hdr0", 32'(hdr_log[0]), 32'h80);
      chk("t2_hdr1", 32'(hdr_log[1]), 32'h81);
      chk("t2_hdr2", 32'(hdr_log[2]), 32'h82);
      chk("t2_hdr3", 32'(hdr_log[3]), 32'h83);
      chk("t2_hdr4", 32'(hdr_log[4]), 32'h80);
    end
`else
    chk("t2_hdr_none", 32'(hdr_log.size()), 32'd0);
`endif

    // Requester 2 never asserts last: capped at BURST_MAX words
    reset_dut("t3");
    en = 4'b0100;
    for (int k = 0; k < 20; k++) push(2, 8'(8'h60 + k), 1'b0);
    push(3, 8'h7A, 1'b1);
    push(0, 8'h7B, 1'b1);
    push(1, 8'h7C, 1'b1);
    drive();
    repeat (2) tick();
    en = '1;
    drive();
    run_until_idle("t3", 300);
    e8.delete();
    ea.delete();
    for (int k = 0; k < 16; k++) begin
      e8.push_back(8'(8'h60 + k));
      ea.push_back(2);
    end
    e8.push_back(8'h7A); ea.push_back(3);
    e8.push_back(8'h7B); ea.push_back(0);
    e8.push_back(8'h7C); ea.push_back(1);
    for (int k = 16; k < 20; k++) begin
      e8.push_back(8'(8'h60 + k));
      ea.push_back(2);
    end
    chk_ack("t3_ack", ea);
    chk_wr("t3_wr", e8);

    // wfull stall after word 4
    reset_dut("t4");
    for (int k = 1; k <= 8; k++) push(1, 8'(k), k == 8);
    drive();
    n = 0;
    while (ack_log.size() < 4 && n < 50) begin
      tick();
      n++;
    end
    chk("t4_reach4", 32'(ack_log.size()), 32'd4);
    bus.wfull = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("t4_stall_winc%0d", c), 32'(s_winc), 32'd0);
      chk($sformatf("t4_stall_ack%0d", c), 32'(s_ack), 32'd0);
    end
    chk("t4_busy_stall", 32'(bus.busy), 32'd1);
    bus.wfull = 1'b0;
    run_until_idle("t4", 100);
    e8.delete();
    for (int k = 1; k <= 8; k++) e8.push_back(8'(k));
    chk_wr("t4_wr", e8);

    // Requester 1 drops req after 2 of 4 words
    reset_dut("t5");
    for (int k = 1; k <= 4; k++) push(1, 8'(8'h20 + k), 1'b0);
    push(2, 8'h35, 1'b1);
    drive();
    n = 0;
    while (ack_log.size() < 2 && n < 50) begin
      tick();
      n++;
    end
    en[1] = 1'b0;
    drive();
    run_until_idle("t5", 100);
    ea = '{1, 1, 2};
    chk_ack("t5_ack", ea);
    e8 = '{8'h21, 8'h22, 8'h35};
    chk_wr("t5_wr", e8);

    // Asynchronous reset mid-burst
    reset_dut("t6");
    for (int k = 1; k <= 6; k++) push(3, 8'(8'h50 + k), k == 6);
    drive();
    n = 0;
    while (ack_log.size() < 2 && n < 50) begin
      tick();
      n++;
    end
    chk("t6_owner_pre", 32'(bus.owner), 32'd3);
    push(0, 8'h4F, 1'b1);
    drive();
    #2;
    wrst_n = 1'b0;
    #1;
    chk("t6_async_winc",  32'(bus.winc),  32'd0);
    chk("t6_async_ack",   32'(bus.ack),   32'd0);
    chk("t6_async_busy",  32'(bus.busy),  32'd0);
    chk("t6_async_owner", 32'(bus.owner), 32'd0);
    @(posedge wclk);
    #1;
    wrst_n = 1'b1;
    clear_logs();
    run_until_idle("t6", 100);
    ea = '{0, 3, 3, 3, 3};
    chk_ack("t6_ack", ea);
    e8 = '{8'h4F, 8'h53, 8'h54, 8'h55, 8'h56};
    chk_wr("t6_wr", e8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
